// File: rtl/bus_sigs_checker_if.sv
// Signal bundle between a bus_sigs response checker and whatever drives its samples.
// The master side supplies samples and start; the slave side (the checker) returns results.
interface bus_sigs_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    // Handshake: sample_vld has no ready. Every cycle with sample_vld=1 while the checker
    // is busy is consumed on that clock edge; dut_bus/exp_bus must be stable with it.
    logic             start;
    logic             sample_vld;
    logic [WIDTH-1:0] dut_bus;
    logic [WIDTH-1:0] exp_bus;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_idx;
    logic [WIDTH-1:0] first_err_got;
    logic [WIDTH-1:0] first_err_exp;
    logic [WIDTH-1:0] signature;

    modport master (
        output start, sample_vld, dut_bus, exp_bus,
        input  busy, done, pass, sample_cnt, err_cnt,
        input  first_err_idx, first_err_got, first_err_exp, signature
    );

    modport slave (
        input  start, sample_vld, dut_bus, exp_bus,
        output busy, done, pass, sample_cnt, err_cnt,
        output first_err_idx, first_err_got, first_err_exp, signature
    );
endinterface

// File: rtl/bus_sigs_checker.sv
// Response checker: compares accepted DUT samples with expected values, counts errors,
// captures the first mismatch and compacts all observed samples into a MISR signature.
module bus_sigs_checker #(
    parameter int               WIDTH       = 4,
    parameter int               CNT_W       = 8,
    parameter int               MAX_SAMPLES = 16,
    parameter logic [WIDTH-1:0] POLY        = 4'b0011
) (
    input  logic                clk,
    input  logic                rst,
    bus_sigs_checker_if.slave   bus,
    output logic [1:0]          state_dbg
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             busy_r, done_r, pass_r;
    logic [CNT_W-1:0] sample_cnt_r, err_cnt_r, first_err_idx_r;
    logic [WIDTH-1:0] first_err_got_r, first_err_exp_r, signature_r;

    logic             mismatch;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] err_next;
    logic [WIDTH-1:0] sig_next;

    always_comb begin
        mismatch = (bus.dut_bus != bus.exp_bus);
        cnt_inc  = sample_cnt_r + 1'b1;
        err_next = err_cnt_r;
        if (mismatch && (err_cnt_r != '1)) err_next = err_cnt_r + 1'b1;
        sig_next = {signature_r[WIDTH-2:0], 1'b0}
                 ^ (signature_r[WIDTH-1] ? POLY : '0)
                 ^ bus.dut_bus;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            sample_cnt_r    <= '0;
            err_cnt_r       <= '0;
            first_err_idx_r <= '0;
            first_err_got_r <= '0;
            first_err_exp_r <= '0;
            signature_r     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Samples presented alongside start belong to no run and are dropped.
                    if (bus.start) begin
                        state           <= RUN;
                        busy_r          <= 1'b1;
                        done_r          <= 1'b0;
                        pass_r          <= 1'b0;
                        sample_cnt_r    <= '0;
                        err_cnt_r       <= '0;
                        first_err_idx_r <= '0;
                        first_err_got_r <= '0;
                        first_err_exp_r <= '0;
                        signature_r     <= '0;
                    end
                end
                RUN: begin
                    if (bus.sample_vld) begin
                        sample_cnt_r <= cnt_inc;
                        err_cnt_r    <= err_next;
                        signature_r  <= sig_next;
                        if (mismatch && (err_cnt_r == '0)) begin
                            first_err_idx_r <= sample_cnt_r;
                            first_err_got_r <= bus.dut_bus;
                            first_err_exp_r <= bus.exp_bus;
                        end
                        if (cnt_inc == CNT_W'(MAX_SAMPLES)) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            pass_r <= (err_next == '0);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    pass_r <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg         = state;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.pass          = pass_r;
    assign bus.sample_cnt    = sample_cnt_r;
    assign bus.err_cnt       = err_cnt_r;
    assign bus.first_err_idx = first_err_idx_r;
    assign bus.first_err_got = first_err_got_r;
    assign bus.first_err_exp = first_err_exp_r;
    assign bus.signature     = signature_r;
endmodule

// File: tb/tb_bus_sigs_checker.sv
// Directed bench for bus_sigs_checker: a vector table for the clean 16-sample run plus
// hand-written sequences for errors, MISR steps, ignored start/vld, mid-run reset and restart.
module tb_bus_sigs_checker;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  logic [1:0] state_dbg;

  bus_sigs_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  bus_sigs_checker #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_SAMPLES(16), .POLY(4'b0011)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       vld;
    logic [3:0] dut_v;
    logic [3:0] exp_v;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] cnt;
    logic [7:0] err;
    logic [3:0] sig;
  } vec_t;

  vec_t tbl [17];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, req, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic busy, input logic done, input logic pass,
                          input logic [7:0] cnt, input logic [7:0] err);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(done));
    chk({tag, ".pass"}, 32'(bus.pass), 32'(pass));
    chk({tag, ".sample_cnt"}, 32'(bus.sample_cnt), 32'(cnt));
    chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(err));
  endtask

  // driver: apply inputs, take one clock edge, leave outputs ready to sample at edge+1
  task automatic step(input logic st, input logic vld, input logic [3:0] d, input logic [3:0] e);
    bus.start      = st;
    bus.sample_vld = vld;
    bus.dut_bus    = d;
    bus.exp_bus    = e;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.sample_vld = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].start, tbl[i].vld, tbl[i].dut_v, tbl[i].exp_v);
      chk_outs($sformatf("%s[%0d]", tag, i), tbl[i].busy, tbl[i].done, tbl[i].pass,
               tbl[i].cnt, tbl[i].err);
      chk($sformatf("%s[%0d].signature", tag, i), 32'(bus.signature), 32'(tbl[i].sig));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_outs(tag, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk({tag, ".first_err_idx"}, 32'(bus.first_err_idx), 32'd0);
    chk({tag, ".first_err_got"}, 32'(bus.first_err_got), 32'd0);
    chk({tag, ".first_err_exp"}, 32'(bus.first_err_exp), 32'd0);
    chk({tag, ".signature"}, 32'(bus.signature), 32'd0);
  endtask

  initial begin
    logic [3:0] sig_tab [16];
    int acc;
    logic saw_done;

    // MISR after each of dut = 0..15 from a cleared signature, POLY = 0011
    sig_tab = '{4'h0, 4'h1, 4'h0, 4'h3, 4'h2, 4'h1, 4'h4, 4'hF,
                4'h5, 4'h3, 4'hC, 4'h0, 4'hC, 4'h6, 4'h2, 4'hB};
    tbl[0] = '{start: 1'b1, vld: 1'b0, dut_v: 4'h0, exp_v: 4'h0, busy: 1'b1, done: 1'b0,
               pass: 1'b0, cnt: 8'd0, err: 8'd0, sig: 4'h0};
    for (int i = 1; i <= 16; i++) begin
      tbl[i] = '{start: 1'b0, vld: 1'b1, dut_v: 4'(i - 1), exp_v: 4'(i - 1),
                 busy: (i != 16), done: (i == 16), pass: (i == 16),
                 cnt: 8'(i), err: 8'd0, sig: sig_tab[i-1]};
    end

    bus.start = 1'b0; bus.sample_vld = 1'b0; bus.dut_bus = '0; bus.exp_bus = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset.state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // vld while IDLE is ignored
    step(1'b0, 1'b1, 4'h3, 4'h5);
    chk_all_zero("idle_vld");

    // scenario 1: clean run from table
    run_table("clean");

    // scenario 2: two mismatches, first at index 5
    step(1'b1, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      if (i == 5)      step(1'b0, 1'b1, 4'b0011, 4'b0010);
      else if (i == 9) step(1'b0, 1'b1, 4'h1, 4'h0);
      else             step(1'b0, 1'b1, 4'(i), 4'(i));
    end
    chk_outs("errs", 1'b0, 1'b1, 1'b0, 8'd16, 8'd2);
    chk("errs.first_err_idx", 32'(bus.first_err_idx), 32'd5);
    chk("errs.first_err_got", 32'(bus.first_err_got), 32'd3);
    chk("errs.first_err_exp", 32'(bus.first_err_exp), 32'd2);

    // results hold in DONE over idle cycles
    step(1'b0, 1'b0, 4'h0, 4'h0);
    chk_outs("errs_hold", 1'b0, 1'b1, 1'b0, 8'd16, 8'd2);

    // scenario 6: restart from failed DONE clears everything
    step(1'b1, 1'b0, 4'h0, 4'h0);
    chk_outs("restart", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("restart.first_err_idx", 32'(bus.first_err_idx), 32'd0);
    chk("restart.first_err_got", 32'(bus.first_err_got), 32'd0);
    chk("restart.first_err_exp", 32'(bus.first_err_exp), 32'd0);
    chk("restart.signature", 32'(bus.signature), 32'd0);

    // scenario 3: MISR steps 1,0,0,0,0 -> 1,2,4,8,3
    step(1'b0, 1'b1, 4'h1, 4'h1); chk("misr.s1", 32'(bus.signature), 32'h1);
    step(1'b0, 1'b1, 4'h0, 4'h0); chk("misr.s2", 32'(bus.signature), 32'h2);
    step(1'b0, 1'b0, 4'h7, 4'h0); chk("misr.gap", 32'(bus.signature), 32'h2);
    chk("misr.gap_cnt", 32'(bus.sample_cnt), 32'd2);
    step(1'b0, 1'b1, 4'h0, 4'h0); chk("misr.s3", 32'(bus.signature), 32'h4);
    step(1'b0, 1'b1, 4'h0, 4'h0); chk("misr.s4", 32'(bus.signature), 32'h8);
    step(1'b0, 1'b1, 4'h0, 4'h0); chk("misr.s5", 32'(bus.signature), 32'h3);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 4'h0, 4'h0);
    chk_outs("misr_end", 1'b0, 1'b1, 1'b1, 8'd16, 8'd0);
    chk("misr_end.signature", 32'(bus.signature), 32'h1);
    step(1'b1, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'h0, 4'h0);
    chk("zeros.signature", 32'(bus.signature), 32'h0);
    chk("zeros.done", 32'(bus.done), 32'd1);

    // scenario 4: vld in DONE ignored, start with vld drops the sample, toggling vld
    step(1'b0, 1'b1, 4'h5, 4'h6);
    chk_outs("done_vld", 1'b0, 1'b1, 1'b1, 8'd16, 8'd0);
    step(1'b1, 1'b1, 4'h5, 4'h6);
    chk_outs("start_vld", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    acc = 0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      logic v;
      v = (c % 2 == 0);
      step(c == 9, v, 4'(c), 4'(c));
      if (v && acc < 16) acc++;
      chk($sformatf("toggle[%0d].sample_cnt", c), 32'(bus.sample_cnt), 32'(acc));
      chk($sformatf("toggle[%0d].done", c), 32'(bus.done), 32'(acc == 16));
      chk($sformatf("toggle[%0d].busy", c), 32'(bus.busy), 32'(acc != 16));
      if (bus.done) saw_done = 1'b1;
    end
    chk("toggle.reached_done", 32'(saw_done), 32'd1);
    chk("toggle.pass", 32'(bus.pass), 32'd1);

    // scenario 5: asynchronous reset between edges after sample 7
    step(1'b1, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'(i), 4'(i + 1));
    chk("pre_rst.err_cnt", 32'(bus.err_cnt), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst.state", 32'(state_dbg), 32'd0);
    #1 rst = 1'b0;
    step(1'b0, 1'b1, 4'h2, 4'h3);
    chk_all_zero("post_rst_idle");
    run_table("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
